optical_frame_receiver: RTL and testbench

- Receive-side decoder for the optical audio link; it consumes the serial biphase-mark stream that the transmitter FPGA drives onto its ja pins.
- Oversamples the line, recovers half-bit cells, finds subframe preambles and decodes 32-slot subframes.
- Delivers each 20-bit audio field and its payload byte to the downstream receive FIFO, one valid strobe per subframe, and reports lock and error status.

---
 rtl/optical_link_pkg.sv | 15 +
 rtl/pulse_classifier.sv | 38 +++
 rtl/optical_frame_receiver.sv | 132 +++++++++++++
 tb/tb_optical_frame_receiver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/optical_link_pkg.sv
// optical_link_pkg: shared types, subframe constants and bit-reverse helper for the optical receiver
package optical_link_pkg;
  typedef enum logic [2:0] {GLITCH, U1, U2, U3, TIMEOUT} pulse_class_t;
  typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W} preamble_t;
  typedef enum logic [2:0] {HUNT, PRE, DATA, CHECK, PRE_WAIT} rx_state_t;
  localparam int SUBFRAME_SLOTS = 32;
  localparam int AUDIO_LSB_SLOT = 8;
  localparam int AUDIO_MSB_SLOT = 27;
  localparam int PREAMBLE_UI = 8;
  function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction
endpackage

// File: rtl/pulse_classifier.sv
// pulse_classifier: syncs rx_in, times each pulse, strobes pulse_strobe with pulse_class (TIMEOUT without an edge)
module pulse_classifier
  import optical_link_pkg::*;
#(
  parameter int SHORT_MIN = 4,
  parameter int SHORT_MAX = 12,
  parameter int LONG_MAX = 20,
  parameter int PRE_MAX = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_in,
  output logic         pulse_strobe,
  output pulse_class_t pulse_class
);
  localparam int WW = $clog2(PRE_MAX + 2);
  logic [2:0] sync;
  logic [WW-1:0] width;
  logic timed_out, edge_seen, over;
  assign edge_seen = sync[2] ^ sync[1];
  assign over = width > WW'(PRE_MAX);
  // a timeout is reported once; the edge that finally ends that pulse is swallowed
  assign pulse_strobe = (edge_seen || over) && !timed_out;
  assign pulse_class = width < WW'(SHORT_MIN) ? GLITCH :
                       width <= WW'(SHORT_MAX) ? U1 :
                       width <= WW'(LONG_MAX) ? U2 :
                       over ? TIMEOUT : U3;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync <= '0;
      width <= '0;
      timed_out <= 1'b0;
    end else begin
      sync <= {sync[1:0], rx_in};
      width <= edge_seen ? WW'(1) : over ? width : width + WW'(1);
      timed_out <= !edge_seen && (timed_out || over);
    end
endmodule

// File: rtl/optical_frame_receiver.sv
// optical_frame_receiver: BMC subframe decoder; rx_in in, sample_out/byte_out/channel/block_start/sample_valid, locked/parity_err/err_count out
module optical_frame_receiver
  import optical_link_pkg::*;
#(
  parameter int SHORT_MIN = 4,
  parameter int SHORT_MAX = 12,
  parameter int LONG_MAX = 20,
  parameter int PRE_MAX = 28,
  parameter int LOCK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_in,
  output logic [19:0] sample_out,
  output logic [7:0]  byte_out,
  output logic        channel,
  output logic        block_start,
  output logic        sample_valid,
  output logic        locked,
  output logic        parity_err,
  output logic [7:0]  err_count
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  pulse_class_t pc;
  rx_state_t state;
  preamble_t pre;
  logic ps, pre_first, half_pending, line_err, bad_pulse;
  logic [3:0] ui_cnt, ui_sum;
  logic [4:0] bit_idx;
  logic [31:4] slots;
  logic [GW-1:0] good_cnt, good_next;
  pulse_classifier #(
    .SHORT_MIN(SHORT_MIN),
    .SHORT_MAX(SHORT_MAX),
    .LONG_MAX(LONG_MAX),
    .PRE_MAX(PRE_MAX)
  ) u_cls (
    .clk(clk),
    .rst_n(rst_n),
    .rx_in(rx_in),
    .pulse_strobe(ps),
    .pulse_class(pc)
  );
  always_comb begin
    bad_pulse = pc == GLITCH || pc == TIMEOUT;
    ui_sum = ui_cnt + (pc == U1 ? 4'd1 : pc == U2 ? 4'd2 : 4'd3);
    good_next = good_cnt == GW'(LOCK_FRAMES) ? good_cnt : good_cnt + GW'(1);
    // HUNT ignores everything, so it never produces a line error
    line_err = ps && (state == PRE ? bad_pulse || ui_sum > 4'(PREAMBLE_UI) :
                      state == DATA ? bad_pulse || pc == U3 || (pc == U2 && half_pending) :
                      state == CHECK ? bad_pulse :
                      state == PRE_WAIT ? pc != U3 : 1'b0);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= HUNT;
      pre <= PRE_B;
      pre_first <= 1'b0;
      half_pending <= 1'b0;
      ui_cnt <= '0;
      bit_idx <= '0;
      slots <= '0;
      good_cnt <= '0;
      sample_out <= '0;
      byte_out <= '0;
      channel <= 1'b0;
      block_start <= 1'b0;
      sample_valid <= 1'b0;
      locked <= 1'b0;
      parity_err <= 1'b0;
      err_count <= '0;
    end else begin
      sample_valid <= 1'b0;
      parity_err <= 1'b0;
      if (line_err) begin
        err_count <= err_count == 8'hFF ? err_count : err_count + 8'd1;
        locked <= 1'b0;
        good_cnt <= '0;
        // a U3 inside data is already the start of the next preamble
        state <= (state == DATA && pc == U3) ? PRE : HUNT;
        ui_cnt <= 4'd3;
        pre_first <= 1'b1;
      end else
        case (state)
          HUNT, PRE_WAIT:
            if (ps && pc == U3) begin
              state <= PRE;
              ui_cnt <= 4'd3;
              pre_first <= 1'b1;
            end
          PRE:
            if (ps) begin
              ui_cnt <= ui_sum;
              pre_first <= 1'b0;
              if (pre_first) pre <= pc == U1 ? PRE_B : pc == U3 ? PRE_M : PRE_W;
              if (ui_sum == 4'(PREAMBLE_UI)) begin
                state <= DATA;
                bit_idx <= 5'd4;
                half_pending <= 1'b0;
              end
            end
          DATA:
            if (ps) begin
              if (pc == U1 && !half_pending) half_pending <= 1'b1;
              else begin
                slots[bit_idx] <= pc == U1;
                half_pending <= 1'b0;
                bit_idx <= bit_idx + 5'd1;
                if (bit_idx == 5'(SUBFRAME_SLOTS - 1)) state <= CHECK;
              end
            end
          CHECK: begin
            state <= PRE_WAIT;
            if (~^slots) begin
              good_cnt <= good_next;
              if (locked || good_next == GW'(LOCK_FRAMES)) begin
                locked <= 1'b1;
                sample_valid <= 1'b1;
                sample_out <= slots[AUDIO_MSB_SLOT:AUDIO_LSB_SLOT];
                byte_out <= bit_reverse8(slots[AUDIO_LSB_SLOT+13:AUDIO_LSB_SLOT+6]);
                channel <= pre == PRE_W;
                block_start <= pre == PRE_B;
              end
            end else begin
              parity_err <= 1'b1;
              good_cnt <= '0;
            end
          end
          default: state <= HUNT;
        endcase
    end
endmodule

// File: tb/tb_optical_frame_receiver.sv
// tb_optical_frame_receiver: directed BMC stimulus with hand-computed expectations for optical_frame_receiver
module tb_optical_frame_receiver;
  localparam int PB = 0;
  localparam int PM = 1;
  localparam int PW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b0;
  logic [19:0] sample_out;
  logic [7:0] byte_out, err_count;
  logic channel, block_start, sample_valid, locked, parity_err;
  int tests = 0;
  int fails = 0;
  int sv_cnt = 0;
  int pe_cnt = 0;
  logic [19:0] cap_sample = '0;
  logic [7:0] cap_byte = '0;
  logic cap_channel = 1'b0;
  logic cap_block = 1'b0;
  logic jit = 1'b0;
  logic alt = 1'b0;
  always #5 clk = ~clk;
  optical_frame_receiver dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_in(rx_in),
    .sample_out(sample_out),
    .byte_out(byte_out),
    .channel(channel),
    .block_start(block_start),
    .sample_valid(sample_valid),
    .locked(locked),
    .parity_err(parity_err),
    .err_count(err_count)
  );
  always @(negedge clk) begin
    if (sample_valid) begin
      sv_cnt++;
      cap_sample = sample_out;
      cap_byte = byte_out;
      cap_channel = channel;
      cap_block = block_start;
    end
    if (parity_err) pe_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic raw(input int w);
    rx_in = ~rx_in;
    repeat (w) @(negedge clk);
  endtask
  task automatic pulse(input int n);
    raw(n * 8 + (jit ? (alt ? 1 : -1) : 0));
    alt = ~alt;
  endtask
  task automatic send_sf(input int kind, input logic [19:0] audio, input logic flip, input int gslot);
    logic [31:0] s;
    s = 32'd0;
    s[27:8] = audio;
    s[31] = ^s[30:4] ^ flip;
    pulse(3);
    if (kind == PB) begin pulse(1); pulse(1); pulse(3); end
    else if (kind == PM) begin pulse(3); pulse(1); pulse(1); end
    else begin pulse(2); pulse(1); pulse(2); end
    for (int i = 4; i < 32; i++) begin
      if (i == gslot) raw(2);
      if (s[i]) begin pulse(1); pulse(1); end
      else pulse(2);
    end
  endtask
  initial begin
    @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sample", 32'(sample_out), 0);
    check("rst_byte", 32'(byte_out), 0);
    check("rst_channel", 32'(channel), 0);
    check("rst_block", 32'(block_start), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_parity", 32'(parity_err), 0);
    check("rst_err", 32'(err_count), 0);
    rst_n = 1'b1;
    repeat (8) pulse(1);
    check("hunt_no_valid", sv_cnt, 0);
    check("hunt_err", 32'(err_count), 0);
    send_sf(PB, 20'h00000, 1'b0, 0);
    send_sf(PW, 20'h03FC0, 1'b0, 0);
    send_sf(PM, 20'hABCDE, 1'b0, 0);
    send_sf(PW, 20'h12345, 1'b0, 0);
    check("lock_not_yet", 32'(locked), 0);
    check("lock_no_valid", sv_cnt, 0);
    send_sf(PM, 20'h00040, 1'b0, 0);
    check("lock_sf4", 32'(locked), 1);
    check("sv_sf4", sv_cnt, 1);
    check("sample_sf4", 32'(cap_sample), 32'h12345);
    check("byte_sf4", 32'(cap_byte), 32'hB1);
    check("chan_sf4", 32'(cap_channel), 1);
    check("blk_sf4", 32'(cap_block), 0);
    send_sf(PW, 20'h00001, 1'b1, 0);
    check("sv_sf5", sv_cnt, 2);
    check("sample_sf5", 32'(cap_sample), 32'h00040);
    check("byte_sf5", 32'(cap_byte), 32'h80);
    check("chan_sf5", 32'(cap_channel), 0);
    check("blk_sf5", 32'(cap_block), 0);
    send_sf(PB, 20'h0F0F0, 1'b0, 0);
    check("parity_pulse", pe_cnt, 1);
    check("parity_no_valid", sv_cnt, 2);
    check("parity_locked", 32'(locked), 1);
    check("parity_err_cnt", 32'(err_count), 0);
    send_sf(PW, 20'h55555, 1'b0, 12);
    check("sv_sf7", sv_cnt, 3);
    check("sample_sf7", 32'(cap_sample), 32'h0F0F0);
    check("byte_sf7", 32'(cap_byte), 32'hC3);
    check("blk_sf7", 32'(cap_block), 1);
    check("glitch_err", 32'(err_count), 1);
    check("glitch_unlock", 32'(locked), 0);
    send_sf(PB, 20'h00001, 1'b0, 0);
    send_sf(PW, 20'h00002, 1'b0, 0);
    send_sf(PM, 20'h00003, 1'b0, 0);
    send_sf(PW, 20'h00004, 1'b0, 0);
    check("relock_not_yet", 32'(locked), 0);
    check("relock_no_valid", sv_cnt, 3);
    send_sf(PM, 20'h00005, 1'b0, 0);
    check("relock", 32'(locked), 1);
    check("relock_sv", sv_cnt, 4);
    check("relock_sample", 32'(cap_sample), 32'h00004);
    rx_in = ~rx_in;
    repeat (30) @(negedge clk);
    check("to_before", 32'(locked), 1);
    check("to_sv", sv_cnt, 5);
    repeat (3) @(negedge clk);
    check("to_unlock", 32'(locked), 0);
    repeat (7) @(negedge clk);
    check("to_err", 32'(err_count), 2);
    jit = 1'b1;
    send_sf(PB, 20'h11111, 1'b0, 0);
    send_sf(PW, 20'h22222, 1'b0, 0);
    send_sf(PM, 20'h54321, 1'b0, 0);
    send_sf(PW, 20'hFEDCB, 1'b0, 0);
    send_sf(PM, 20'h03FC0, 1'b0, 0);
    jit = 1'b0;
    check("jit_locked", 32'(locked), 1);
    check("jit_sv", sv_cnt, 6);
    check("jit_sample", 32'(cap_sample), 32'hFEDCB);
    check("jit_byte", 32'(cap_byte), 32'hED);
    check("jit_chan", 32'(cap_channel), 1);
    check("jit_err", 32'(err_count), 2);
    for (int i = 0; i < 100; i++) begin raw(24); raw(2); end
    check("jit_last_sv", sv_cnt, 7);
    check("jit_last_sample", 32'(cap_sample), 32'h03FC0);
    check("jit_last_byte", 32'(cap_byte), 32'hFF);
    check("jit_last_chan", 32'(cap_channel), 0);
    check("sat_mid", 32'(err_count), 101);
    for (int i = 0; i < 200; i++) begin raw(24); raw(2); end
    raw(24);
    repeat (10) @(negedge clk);
    check("sat_err", 32'(err_count), 255);
    check("sat_locked", 32'(locked), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
